dp_uram_pipe: RTL and testbench

DP_URAM_PIPE -- requirements
Module: dp_uram_pipe

---
 rtl/dp_uram_pipe_if.sv | 29 ++
 rtl/dp_uram_pipe.sv | 85 ++++++++
 tb/tb_dp_uram_pipe.sv | 202 ++++++++++++++++++++
 3 files changed

// File: rtl/dp_uram_pipe_if.sv
// Port bundle for dp_uram_pipe: byte-masked write port A, tagged read port B, collision counter.
// The master side drives requests; the slave (memory) side returns read data and the counter.
interface dp_uram_pipe_if #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int TAG_WIDTH  = 4
);
  logic                    wr_en_a;
  logic [DATA_WIDTH/8-1:0] wr_be_a;
  logic [ADDR_WIDTH-1:0]   addr_a;
  logic [DATA_WIDTH-1:0]   din_a;
  logic                    addr_b_vld;
  logic [ADDR_WIDTH-1:0]   addr_b;
  logic [TAG_WIDTH-1:0]    tag_b;
  logic                    dout_b_vld;
  logic [DATA_WIDTH-1:0]   dout_b;
  logic [TAG_WIDTH-1:0]    dout_b_tag;
  logic [15:0]             coll_cnt;

  modport master (
    output wr_en_a, wr_be_a, addr_a, din_a, addr_b_vld, addr_b, tag_b,
    input  dout_b_vld, dout_b, dout_b_tag, coll_cnt
  );

  modport slave (
    input  wr_en_a, wr_be_a, addr_a, din_a, addr_b_vld, addr_b, tag_b,
    output dout_b_vld, dout_b, dout_b_tag, coll_cnt
  );
endinterface

// File: rtl/dp_uram_pipe.sv
// Simple dual-port RAM, write-first with same-cycle byte forwarding; reads return after RD_LATENCY cycles.
// One write and one read accepted every cycle; there is no backpressure.
module dp_uram_pipe #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 14,
  parameter int RD_LATENCY = 3,
  parameter int TAG_WIDTH  = 4
) (
  input  logic             clk,
  input  logic             rst,
  dp_uram_pipe_if.slave    bus
);
  localparam int NB    = DATA_WIDTH / 8;
  localparam int DEPTH = 1 << ADDR_WIDTH;

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  logic                  wr_go;
  logic                  rd_go;
  logic                  coll;
  logic [DATA_WIDTH-1:0] rd_word;

  logic [RD_LATENCY:1]                 vld_q, vld_d;
  logic [RD_LATENCY:1][DATA_WIDTH-1:0] dat_q, dat_d;
  logic [RD_LATENCY:1][TAG_WIDTH-1:0]  tag_q, tag_d;
  logic [15:0]                         coll_cnt_q, coll_cnt_d;

  always_comb begin
    wr_go   = bus.wr_en_a & ~rst;
    rd_go   = bus.addr_b_vld & ~rst;
    coll    = wr_go & rd_go & (bus.addr_a == bus.addr_b);
    // Write-first: bytes being written this cycle bypass the array.
    rd_word = mem[bus.addr_b];
    for (int i = 0; i < NB; i++) begin
      if (coll && bus.wr_be_a[i]) rd_word[8*i +: 8] = bus.din_a[8*i +: 8];
    end

    vld_d    = '0;
    dat_d    = dat_q;
    tag_d    = tag_q;
    vld_d[1] = rd_go;
    dat_d[1] = rd_word;
    tag_d[1] = bus.tag_b;
    for (int k = 2; k <= RD_LATENCY; k++) begin
      vld_d[k] = vld_q[k-1];
      dat_d[k] = dat_q[k-1];
      tag_d[k] = tag_q[k-1];
    end
    // The output stage only loads on a valid beat so idle cycles hold the last result.
    if (!vld_d[RD_LATENCY]) begin
      dat_d[RD_LATENCY] = dat_q[RD_LATENCY];
      tag_d[RD_LATENCY] = tag_q[RD_LATENCY];
    end

    coll_cnt_d = coll_cnt_q;
    if (coll && (|bus.wr_be_a) && (coll_cnt_q != 16'hFFFF)) coll_cnt_d = coll_cnt_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (wr_go) begin
      for (int i = 0; i < NB; i++) begin
        if (bus.wr_be_a[i]) mem[bus.addr_a][8*i +: 8] <= bus.din_a[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      vld_q      <= '0;
      dat_q      <= '0;
      tag_q      <= '0;
      coll_cnt_q <= '0;
    end else begin
      vld_q      <= vld_d;
      dat_q      <= dat_d;
      tag_q      <= tag_d;
      coll_cnt_q <= coll_cnt_d;
    end
  end

  assign bus.dout_b_vld = vld_q[RD_LATENCY];
  assign bus.dout_b     = dat_q[RD_LATENCY];
  assign bus.dout_b_tag = tag_q[RD_LATENCY];
  assign bus.coll_cnt   = coll_cnt_q;
endmodule

// File: tb/tb_dp_uram_pipe.sv
// Drives three instances (RD_LATENCY 1, 3, 6) with identical traffic and checks each cycle
// against a word-array model with per-issue expected results.
module tb_dp_uram_pipe;
  localparam int DW = 32;
  localparam int AW = 14;
  localparam int TW = 4;
  localparam int N  = 131072;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic          wr_en_a = 1'b0;
  logic [3:0]    wr_be_a = '0;
  logic [AW-1:0] addr_a  = '0;
  logic [DW-1:0] din_a   = '0;
  logic          addr_b_vld = 1'b0;
  logic [AW-1:0] addr_b  = '0;
  logic [TW-1:0] tag_b   = '0;

  dp_uram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus1 ();
  dp_uram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus3 ();
  dp_uram_pipe_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .TAG_WIDTH(TW)) bus6 ();

  assign bus1.wr_en_a = wr_en_a;  assign bus3.wr_en_a = wr_en_a;  assign bus6.wr_en_a = wr_en_a;
  assign bus1.wr_be_a = wr_be_a;  assign bus3.wr_be_a = wr_be_a;  assign bus6.wr_be_a = wr_be_a;
  assign bus1.addr_a  = addr_a;   assign bus3.addr_a  = addr_a;   assign bus6.addr_a  = addr_a;
  assign bus1.din_a   = din_a;    assign bus3.din_a   = din_a;    assign bus6.din_a   = din_a;
  assign bus1.addr_b_vld = addr_b_vld;
  assign bus3.addr_b_vld = addr_b_vld;
  assign bus6.addr_b_vld = addr_b_vld;
  assign bus1.addr_b  = addr_b;   assign bus3.addr_b  = addr_b;   assign bus6.addr_b  = addr_b;
  assign bus1.tag_b   = tag_b;    assign bus3.tag_b   = tag_b;    assign bus6.tag_b   = tag_b;

  dp_uram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(1), .TAG_WIDTH(TW))
    u_dut1 (.clk(clk), .rst(rst), .bus(bus1));
  dp_uram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(3), .TAG_WIDTH(TW))
    u_dut3 (.clk(clk), .rst(rst), .bus(bus3));
  dp_uram_pipe #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .RD_LATENCY(6), .TAG_WIDTH(TW))
    u_dut6 (.clk(clk), .rst(rst), .bus(bus6));

  // Reference model: memory contents, and for every clock edge what read (if any) it launched.
  logic [DW-1:0] mem_m [1024];
  bit            iss_v [N];
  logic [DW-1:0] iss_d [N];
  logic [TW-1:0] iss_t [N];
  logic [DW-1:0] exp_dat [3];
  logic [TW-1:0] exp_tag [3];
  logic [15:0]   coll_m = '0;
  int            edge_n = 0;
  int            last_rst_edge = 0;
  int            n_chk = 0;
  int            n_fail = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s edge=%0d got=%0h exp=%0h", nm, edge_n, got, exp);
    end
  endtask

  task automatic check_dut(input int d, input int lat, input logic v,
                           input logic [DW-1:0] dat, input logic [TW-1:0] tg, input logic [15:0] cc);
    int e;
    bit ev;
    e  = edge_n - lat + 1;
    ev = 1'b0;
    if (e >= 1) ev = iss_v[e] && (last_rst_edge < e);
    if (last_rst_edge == edge_n) begin
      exp_dat[d] = '0;
      exp_tag[d] = '0;
    end else if (ev) begin
      exp_dat[d] = iss_d[e];
      exp_tag[d] = iss_t[e];
    end
    chk($sformatf("vld_L%0d", lat), v, ev);
    chk($sformatf("dout_L%0d", lat), dat, exp_dat[d]);
    chk($sformatf("tag_L%0d", lat), tg, exp_tag[d]);
    chk($sformatf("coll_L%0d", lat), cc, coll_m);
  endtask

  // Apply the current inputs to the model, clock once, then compare all three instances.
  task automatic tick();
    int e;
    e = edge_n + 1;
    if (rst) begin
      last_rst_edge = e;
      coll_m = '0;
      iss_v[e] = 1'b0;
    end else begin
      if (wr_en_a) begin
        for (int b = 0; b < 4; b++)
          if (wr_be_a[b]) mem_m[addr_a[9:0]][8*b +: 8] = din_a[8*b +: 8];
      end
      if (wr_en_a && addr_b_vld && addr_a == addr_b && wr_be_a != 4'h0 && coll_m != 16'hFFFF)
        coll_m = coll_m + 16'd1;
      iss_v[e] = addr_b_vld;
      iss_d[e] = mem_m[addr_b[9:0]];
      iss_t[e] = tag_b;
    end
    @(posedge clk);
    edge_n = e;
    @(negedge clk);
    check_dut(0, 1, bus1.dout_b_vld, bus1.dout_b, bus1.dout_b_tag, bus1.coll_cnt);
    check_dut(1, 3, bus3.dout_b_vld, bus3.dout_b, bus3.dout_b_tag, bus3.coll_cnt);
    check_dut(2, 6, bus6.dout_b_vld, bus6.dout_b, bus6.dout_b_tag, bus6.coll_cnt);
  endtask

  task automatic idle(input int n);
    wr_en_a = 1'b0;
    addr_b_vld = 1'b0;
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic wr(input int a, input logic [DW-1:0] d, input logic [3:0] be);
    wr_en_a = 1'b1; addr_a = AW'(a); din_a = d; wr_be_a = be;
  endtask

  task automatic rd(input int a, input int t);
    addr_b_vld = 1'b1; addr_b = AW'(a); tag_b = TW'(t);
  endtask

  initial begin
    for (int d = 0; d < 3; d++) begin
      exp_dat[d] = '0;
      exp_tag[d] = '0;
    end
    rst = 1'b1;
    idle(3);
    rst = 1'b0;

    // Preload every address the bench will read.
    for (int a = 0; a < 64; a++) begin
      wr(a, $urandom, 4'hF); addr_b_vld = 1'b0; tick();
    end
    idle(2);

    // Basic write then read.
    wr(5, 32'hDEADBEEF, 4'hF); tick();
    wr_en_a = 1'b0; rd(5, 3); tick();
    idle(8);

    // Byte-enabled partial write.
    wr(9, 32'h11223344, 4'hF); tick();
    wr(9, 32'hAABBCCDD, 4'h5); tick();
    wr_en_a = 1'b0; rd(9, 1); tick();
    idle(8);

    // Same-cycle collision with partial enables.
    wr(7, 32'h0, 4'hF); tick();
    wr(7, 32'h12345678, 4'hC); rd(7, 2); tick();
    idle(8);

    // Collision with no bytes enabled: no update, no count.
    wr(7, 32'hFFFFFFFF, 4'h0); rd(7, 4); tick();
    idle(8);

    // Streaming reads 0..15.
    wr_en_a = 1'b0;
    for (int i = 0; i < 16; i++) begin
      rd(i, i); tick();
    end
    idle(8);

    // Random mixed traffic over a small address window to provoke collisions.
    for (int i = 0; i < 2000; i++) begin
      wr_en_a = 1'($urandom_range(0, 1));
      wr_be_a = 4'($urandom_range(0, 15));
      addr_a  = AW'($urandom_range(0, 15));
      din_a   = $urandom;
      addr_b_vld = 1'($urandom_range(0, 1));
      addr_b  = AW'($urandom_range(0, 15));
      tag_b   = TW'($urandom_range(0, 15));
      tick();
    end
    idle(8);

    // Reset with reads in flight; traffic during reset must be ignored.
    wr(3, 32'hCAFEF00D, 4'hF); tick();
    wr_en_a = 1'b0;
    for (int i = 0; i < 3; i++) begin
      rd(10 + i, 5 + i); tick();
    end
    rst = 1'b1;
    wr(3, 32'h0BADBAD0, 4'hF); rd(3, 9); tick();
    tick();
    rst = 1'b0;
    wr_en_a = 1'b0; rd(3, 11); tick();
    rd(5, 12); tick();
    idle(8);

    // Saturate the collision counter, then keep colliding.
    for (int i = 0; i < 65541; i++) begin
      wr(7, $urandom, 4'hF); rd(7, i % 16); tick();
    end
    idle(8);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
